uart_rx16: RTL and testbench

UART_RX16 -- requirements
Module: uart_rx16

---
 rtl/uart_rx16_if.sv | 29 ++
 rtl/uart_rx16.sv | 116 +++++++++++
 tb/tb_uart_rx16.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx16_if.sv
// Receive-side bundle of the 16x-oversampled UART: the line and baud tick in,
// the received byte, its strobe and the status flags out.
interface uart_rx16_if;
    logic       enable;
    logic       ser_in;
    logic [7:0] dout_byte;
    logic       dout_rdy;
    logic       frame_err;
    logic       rx_busy;

    // master drives the line and the baud tick; slave is the receiver
    modport master (
        output enable,
        output ser_in,
        input  dout_byte,
        input  dout_rdy,
        input  frame_err,
        input  rx_busy
    );

    modport slave (
        input  enable,
        input  ser_in,
        output dout_byte,
        output dout_rdy,
        output frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx16.sv
// 8N1 UART receiver with 16x oversampling: start bit validated mid-bit,
// data and stop bits sampled one full bit period apart from there.
module uart_rx16 #(
    parameter int unsigned MID_SAMPLE = 7
) (
    input  logic         clk,
    input  logic         rst_din_rdy,
    uart_rx16_if.slave   rx
);
    localparam logic [3:0] MID_SC = 4'(MID_SAMPLE);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t     state_q;
    logic [3:0] sc_q;
    logic [2:0] bc_q;
    logic [7:0] shift_q;
    logic [7:0] dout_byte_q;
    logic       dout_rdy_q;
    logic       frame_err_q;
    logic       sync1_q;
    logic       rx_s_q;

    // Two-flop synchronizer; reset to the idle (high) line level
    always_ff @(posedge clk or posedge rst_din_rdy) begin
        if (rst_din_rdy) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx.ser_in;
            rx_s_q  <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge rst_din_rdy) begin
        if (rst_din_rdy) begin
            state_q     <= IDLE;
            sc_q        <= 4'd0;
            bc_q        <= 3'd0;
            shift_q     <= 8'h00;
            dout_byte_q <= 8'h00;
            dout_rdy_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            dout_rdy_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        sc_q    <= 4'd0;
                        bc_q    <= 3'd0;
                    end
                end
                START: begin
                    if (rx.enable) begin
                        if (sc_q == MID_SC) begin
                            sc_q    <= 4'd0;
                            state_q <= rx_s_q ? IDLE : DATA;
                        end else begin
                            sc_q <= sc_q + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (rx.enable) begin
                        sc_q <= sc_q + 4'd1;
                        if (sc_q == 4'd15) begin
                            shift_q <= {rx_s_q, shift_q[7:1]};
                            bc_q    <= bc_q + 3'd1;
                            if (bc_q == 3'd7) begin
                                state_q <= STOP;
                            end
                        end
                    end
                end
                STOP: begin
                    if (rx.enable) begin
                        sc_q <= sc_q + 4'd1;
                        if (sc_q == 4'd15) begin
                            if (rx_s_q) begin
                                dout_byte_q <= shift_q;
                                dout_rdy_q  <= 1'b1;
                                frame_err_q <= 1'b0;
                                state_q     <= IDLE;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= WAIT_HIGH;
                            end
                        end
                    end
                end
                WAIT_HIGH: begin
                    // a held-low (break) line must not look like a new start bit
                    if (rx_s_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx.dout_byte = dout_byte_q;
    assign rx.dout_rdy  = dout_rdy_q;
    assign rx.frame_err = frame_err_q;
    assign rx.rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx16.sv
// Scoreboard bench for uart_rx16: good frames push their byte, the monitor
// pops and compares on each dout_rdy pulse.
module tb_uart_rx16;
    logic clk;
    logic rst_din_rdy;

    uart_rx16_if bus ();

    uart_rx16 #(.MID_SAMPLE(7)) dut (
        .clk         (clk),
        .rst_din_rdy (rst_din_rdy),
        .rx          (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    int         tick_div = 1;
    int         tick_cnt = 0;
    int         cyc      = 0;
    int         rdy_cnt  = 0;
    int         busy_cyc = 0;
    int         latency  = 0;
    logic       prev_rdy  = 1'b0;
    logic       prev_busy = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // baud tick generator, updated away from the active edge
    always @(negedge clk) begin
        tick_cnt = (tick_cnt + 1 >= tick_div) ? 0 : tick_cnt + 1;
        bus.enable = (tick_cnt == 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // monitor: scoreboard pops, pulse width and start-to-ready latency
    always @(negedge clk) begin
        if (!rst_din_rdy) begin
            if (bus.rx_busy && !prev_busy) busy_cyc = cyc;
            if (bus.dout_rdy) begin
                check("rdy_pulse_width", {31'd0, prev_rdy}, 32'd0);
                if (!prev_rdy) begin
                    rdy_cnt++;
                    latency = cyc - busy_cyc;
                    if (exp_q.size() == 0) begin
                        check("unexpected_rdy", 32'd1, 32'd0);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        check("rx_byte", {24'd0, bus.dout_byte}, {24'd0, e});
                        $display("rx byte 0x%02h expected 0x%02h latency=%0d", bus.dout_byte, e, latency);
                    end
                    check("ferr_on_good", {31'd0, bus.frame_err}, 32'd0);
                end
            end
        end
        prev_rdy  = bus.dout_rdy;
        prev_busy = bus.rx_busy;
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!bus.enable) @(posedge clk);
        end
        #1;
    endtask

    // leaves the line at the stop-bit level
    task automatic send_frame(input logic [7:0] d, input logic stop);
        bus.ser_in = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            bus.ser_in = d[i];
            wait_ticks(16);
        end
        bus.ser_in = stop;
        wait_ticks(16);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        bus.ser_in  = 1'b1;
        rst_din_rdy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_dout_byte", {24'd0, bus.dout_byte}, 32'h00);
        check("rst_dout_rdy",  {31'd0, bus.dout_rdy},  32'd0);
        check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        check("rst_rx_busy",   {31'd0, bus.rx_busy},   32'd0);
        rst_din_rdy = 1'b0;
        wait_ticks(20);

        // 0xA5, enable every clk; stop sampled 8 + 16*9 ticks after START entry
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_ticks(20);
        check("a5_rdy_count", rdy_cnt, 1);
        check("a5_latency", latency, 8 + 16 * 9);
        check("a5_frame_err", {31'd0, bus.frame_err}, 32'd0);

        // false start: low for 4 ticks only
        n0 = rdy_cnt;
        bus.ser_in = 1'b0;
        wait_ticks(4);
        bus.ser_in = 1'b1;
        wait_ticks(2);
        check("false_start_busy", {31'd0, bus.rx_busy}, 32'd1);
        wait_ticks(12);
        check("false_start_idle", {31'd0, bus.rx_busy}, 32'd0);
        check("false_start_rdy", rdy_cnt, n0);
        check("false_start_byte", {24'd0, bus.dout_byte}, 32'hA5);

        // 0x3C with bad stop, line held low (break), then 0x55
        send_frame(8'h3C, 1'b0);
        wait_ticks(40);
        check("break_frame_err", {31'd0, bus.frame_err}, 32'd1);
        check("break_wait_high", {31'd0, bus.rx_busy}, 32'd1);
        check("break_byte_held", {24'd0, bus.dout_byte}, 32'hA5);
        check("break_no_rdy", rdy_cnt, n0);
        bus.ser_in = 1'b1;
        wait_ticks(4);
        check("break_exit_idle", {31'd0, bus.rx_busy}, 32'd0);
        wait_ticks(16);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        wait_ticks(20);
        check("x55_rdy_count", rdy_cnt, n0 + 1);
        check("x55_frame_err", {31'd0, bus.frame_err}, 32'd0);

        // enable every 4th clk
        tick_div = 4;
        wait_ticks(4);
        n0 = rdy_cnt;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        wait_ticks(20);
        check("x81_rdy_count", rdy_cnt, n0 + 1);
        check("x81_byte", {24'd0, bus.dout_byte}, 32'h81);
        tick_div = 1;
        wait_ticks(4);

        // reset after 3 data bits of 0x0F
        n0 = rdy_cnt;
        bus.ser_in = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            bus.ser_in = 1'b1;
            wait_ticks(16);
        end
        rst_din_rdy = 1'b1;
        #1;
        check("midrst_dout_byte", {24'd0, bus.dout_byte}, 32'h00);
        check("midrst_dout_rdy",  {31'd0, bus.dout_rdy},  32'd0);
        check("midrst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        check("midrst_rx_busy",   {31'd0, bus.rx_busy},   32'd0);
        @(posedge clk);
        #1;
        rst_din_rdy = 1'b0;
        bus.ser_in  = 1'b1;
        wait_ticks(20);
        check("midrst_no_rdy", rdy_cnt, n0);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1);
        wait_ticks(20);
        check("xff_rdy_count", rdy_cnt, n0 + 1);

        // back-to-back frames with no idle gap
        n0 = rdy_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_ticks(20);
        check("b2b_rdy_count", rdy_cnt, n0 + 2);
        check("b2b_frame_err", {31'd0, bus.frame_err}, 32'd0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
